myooo_inst_buffer: RTL and testbench
====================================

Name: myooo_inst_buffer

Overview:
- Instruction buffer between the I-cache fetch stage and the decode/dispatch stage of the myooo core.
- Accepts 64-bit fetch groups, each holding two 32-bit instruction slots with a per-slot valid mask.
- Compacts the valid slots into an in-order circular queue of INST_BUF_SIZE instruction entries.
- Presents up to DISP_SIZE oldest instructions per cycle to dispatch under a valid/ready handshake, and is cleared by pipeline flush.

Parameters:
- FETCH_W, 64: fetch group width in bits; fixed at 2 slots × 32 bits.
- INST_BUF_SIZE, 6: queue depth in 32-bit instructions; must be ≥ 2.
- DISP_SIZE, 2: maximum instructions presented per cycle; must be ≤ INST_BUF_SIZE.
- PC_W, 39: virtual PC width.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_flush  in  1  pipeline flush; discard all contents
- i_fetch_valid  in  1  fetch group valid
- o_fetch_ready  out  1  buffer can accept a full group
- i_fetch_pc  in  PC_W  PC of slot 0; 8-byte aligned
- i_fetch_inst  in  FETCH_W  slot0 = [31:0], slot1 = [63:32]
- i_fetch_mask  in  2  per-slot valid
- o_disp_valid  out  1  at least one instruction presented
- o_disp_mask  out  DISP_SIZE  thermometer mask of presented lanes
- o_disp_inst  out  DISP_SIZE*32  lane k = oldest+k instruction
- o_disp_pc  out  DISP_SIZE*PC_W  lane k PC
- i_disp_ready  in  1  dispatch consumes all presented lanes
- o_count  out  $clog2(INST_BUF_SIZE+1)  occupied entries
- o_stall_cycles  out  32  fetch-stall counter (see Optional Feature)

Behaviour:
- Storage: INST_BUF_SIZE entries of {inst[31:0], pc[PC_W-1:0]}. Read pointer, write pointer and count registers; pointers wrap from INST_BUF_SIZE-1 to 0, with no power-of-2 requirement.
- Reset (asynchronous, i_reset=1): pointers = 0, count = 0, stall counter = 0.
  - Reset outputs: o_fetch_ready=1, o_disp_valid=0, o_disp_mask=0, o_count=0, o_stall_cycles=0.
  - Entry contents are not reset.
- o_fetch_ready = (INST_BUF_SIZE - count ≥ 2) && !i_flush. Computed from the registered count only; a same-cycle pop is not credited.
- Push occurs when i_fetch_valid && o_fetch_ready:
  - Valid slots are written in order (slot0 first) at consecutive wrapped positions starting at the write pointer.
  - Slot k PC = i_fetch_pc + 4k, in PC_W-bit modulo arithmetic.
  - mask=2'b10: slot1 is written at the write pointer with PC i_fetch_pc+4.
  - mask=2'b00: accepted; writes nothing and leaves count unchanged.
- Presentation:
  - n = min(count, DISP_SIZE).
  - o_disp_mask = (1<<n)-1.
  - o_disp_valid = (n≠0) && !i_flush.
  - Lane k shows entry (rptr+k) mod INST_BUF_SIZE. Lanes at or above n are don't-care but must not be X-propagating from reset (drive 0).
- Pop occurs when o_disp_valid && i_disp_ready: rptr advances by n (wrapped). Partial consumption is not supported.
- Count update: count_next = count + pushed - popped, where pushed ∈ {0,1,2}. Simultaneous push and pop are legal in the same cycle.
- Latency: an instruction pushed at edge t is visible on o_disp_* in the cycle after edge t. There is no fetch-to-dispatch bypass.
- Flush: while i_flush=1, push and pop are suppressed. At the next edge, rptr = wptr = count = 0. Flush wins over every simultaneous event.
- Full: count=INST_BUF_SIZE-1 gives o_fetch_ready=0, even for a 1-slot mask.
- Empty: o_disp_valid=0 and i_disp_ready is ignored.
- Reset asserted mid-operation clears the buffer immediately; in-flight handshakes are lost.

Optional Feature:
- Macro: MYOOO_IBUF_PERF_EN.
- Defined: o_stall_cycles increments by 1 on every edge where i_fetch_valid && !o_fetch_ready && !i_flush. It saturates at 32'hFFFF_FFFF and is not cleared by flush.
- Undefined: no counter logic is built, and o_stall_cycles is tied to 0.

Test Plan:
- Reset with no traffic → o_fetch_ready=1, o_disp_valid=0, o_count=0. Push pc=0x1000, mask=11, inst={0x00200093,0x00100013} → next cycle o_disp_mask=11, lane0 pc=0x1000 inst=0x00100013, lane1 pc=0x1004, o_count=2.
- Fill with i_disp_ready=0 using 3 full groups → o_count=6, o_fetch_ready=0. With count=5, o_fetch_ready=0.
- Push mask=10 at pc=0x2008 into an empty buffer → next cycle lane0 pc=0x200C, o_disp_mask=01, o_count=1.
- Continuous push of 2 and pop of 2 for 10 cycles → o_count stays 2, PCs strictly increase by 4 across the wrap boundary, no loss or duplication.
- Buffer holding 4 entries with i_flush=1 and i_fetch_valid=1 → o_disp_valid=0 and o_fetch_ready=0 during the flush cycle; next cycle o_count=0 and the flush-cycle group is not stored.
- With MYOOO_IBUF_PERF_EN defined: full buffer, i_fetch_valid=1 for 7 cycles → o_stall_cycles=7. With the macro undefined → o_stall_cycles=0.

Source files
------------

// File: rtl/myooo_inst_buffer.sv
// Instruction buffer between fetch and dispatch: compacts 2-slot fetch groups into a circular
// queue and presents up to DISP_SIZE oldest entries. Optional stall counter: MYOOO_IBUF_PERF_EN.
module myooo_inst_buffer #(
   parameter int FETCH_W       = 64,
   parameter int INST_BUF_SIZE = 6,
   parameter int DISP_SIZE     = 2,
   parameter int PC_W          = 39
) (
   input  logic                              i_clk,
   input  logic                              i_reset,
   input  logic                              i_flush,
   input  logic                              i_fetch_valid,
   output logic                              o_fetch_ready,
   input  logic [PC_W-1:0]                   i_fetch_pc,
   input  logic [FETCH_W-1:0]                i_fetch_inst,
   input  logic [1:0]                        i_fetch_mask,
   output logic                              o_disp_valid,
   output logic [DISP_SIZE-1:0]              o_disp_mask,
   output logic [DISP_SIZE*32-1:0]           o_disp_inst,
   output logic [DISP_SIZE*PC_W-1:0]         o_disp_pc,
   input  logic                              i_disp_ready,
   output logic [$clog2(INST_BUF_SIZE+1)-1:0] o_count,
   output logic [31:0]                       o_stall_cycles
);
   localparam int PTR_W = (INST_BUF_SIZE > 1) ? $clog2(INST_BUF_SIZE) : 1;
   localparam int CNT_W = $clog2(INST_BUF_SIZE + 1);

   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      ent_inst_q [INST_BUF_SIZE];
   logic [31:0]      ent_inst_d [INST_BUF_SIZE];
   logic [PC_W-1:0]  ent_pc_q   [INST_BUF_SIZE];
   logic [PC_W-1:0]  ent_pc_d   [INST_BUF_SIZE];

   logic fetch_ready, disp_valid, push, pop;
   int   n_avail, n_push;

   // Pointer advance with wrap at INST_BUF_SIZE; amt never exceeds the depth.
   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] ptr, input int amt);
      int sum;
      sum = int'(ptr) + amt;
      if (sum >= INST_BUF_SIZE) sum = sum - INST_BUF_SIZE;
      return PTR_W'(sum);
   endfunction

   always_comb begin
      n_avail     = (int'(count_q) < DISP_SIZE) ? int'(count_q) : DISP_SIZE;
      fetch_ready = ((INST_BUF_SIZE - int'(count_q)) >= 2) && !i_flush;
      disp_valid  = (n_avail != 0) && !i_flush;
      push        = i_fetch_valid && fetch_ready;
      pop         = disp_valid && i_disp_ready;
   end

   always_comb begin
      ent_inst_d = ent_inst_q;
      ent_pc_d   = ent_pc_q;
      rptr_d     = rptr_q;
      wptr_d     = wptr_q;
      count_d    = count_q;
      n_push     = 0;
      if (i_flush) begin
         rptr_d  = '0;
         wptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            if (i_fetch_mask[0]) begin
               ent_inst_d[wptr_q] = i_fetch_inst[31:0];
               ent_pc_d[wptr_q]   = i_fetch_pc;
               n_push             = 1;
            end
            // Slot 1 lands right after slot 0, or at wptr itself when slot 0 is empty.
            if (i_fetch_mask[1]) begin
               ent_inst_d[wrap_add(wptr_q, n_push)] = i_fetch_inst[63:32];
               ent_pc_d[wrap_add(wptr_q, n_push)]   = i_fetch_pc + PC_W'(4);
               n_push                               = n_push + 1;
            end
            wptr_d = wrap_add(wptr_q, n_push);
         end
         if (pop) rptr_d = wrap_add(rptr_q, n_avail);
         count_d = CNT_W'(int'(count_q) + n_push - (pop ? n_avail : 0));
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   // Entry payload carries no reset; unused lanes are masked to zero below.
   always_ff @(posedge i_clk) begin
      ent_inst_q <= ent_inst_d;
      ent_pc_q   <= ent_pc_d;
   end

   always_comb begin
      o_disp_mask = '0;
      o_disp_inst = '0;
      o_disp_pc   = '0;
      for (int k = 0; k < DISP_SIZE; k++) begin
         if (k < n_avail) begin
            o_disp_mask[k]              = 1'b1;
            o_disp_inst[k*32 +: 32]     = ent_inst_q[wrap_add(rptr_q, k)];
            o_disp_pc[k*PC_W +: PC_W]   = ent_pc_q[wrap_add(rptr_q, k)];
         end
      end
   end

   assign o_fetch_ready = fetch_ready;
   assign o_disp_valid  = disp_valid;
   assign o_count       = count_q;

`ifdef MYOOO_IBUF_PERF_EN
   logic [31:0] stall_q, stall_d;

   // Saturating; flush does not clear it.
   always_comb begin
      stall_d = stall_q;
      if (i_fetch_valid && !fetch_ready && !i_flush && (stall_q != 32'hFFFF_FFFF))
         stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) stall_q <= '0;
      else         stall_q <= stall_d;
   end

   assign o_stall_cycles = stall_q;
`else
   assign o_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_myooo_inst_buffer.sv
// Bench for myooo_inst_buffer: queue-based reference model checked every cycle,
// plus directed literal expectations for the key scenarios.
module tb_myooo_inst_buffer;
   localparam int PC_W = 39;
   localparam int SZ   = 6;

   logic            clk;
   logic            i_reset;
   logic            i_flush;
   logic            i_fetch_valid;
   logic            o_fetch_ready;
   logic [PC_W-1:0] i_fetch_pc;
   logic [63:0]     i_fetch_inst;
   logic [1:0]      i_fetch_mask;
   logic            o_disp_valid;
   logic [1:0]      o_disp_mask;
   logic [63:0]     o_disp_inst;
   logic [77:0]     o_disp_pc;
   logic            i_disp_ready;
   logic [2:0]      o_count;
   logic [31:0]     o_stall_cycles;

   int errors = 0;
   int checks = 0;
   bit run    = 0;

   // Scoreboard: each entry is {pc, inst}.
   logic [PC_W+31:0] exp_q[$];
   logic [31:0]      exp_stall = 0;

   myooo_inst_buffer dut (
      .i_clk          (clk),
      .i_reset        (i_reset),
      .i_flush        (i_flush),
      .i_fetch_valid  (i_fetch_valid),
      .o_fetch_ready  (o_fetch_ready),
      .i_fetch_pc     (i_fetch_pc),
      .i_fetch_inst   (i_fetch_inst),
      .i_fetch_mask   (i_fetch_mask),
      .o_disp_valid   (o_disp_valid),
      .o_disp_mask    (o_disp_mask),
      .o_disp_inst    (o_disp_inst),
      .o_disp_pc      (o_disp_pc),
      .i_disp_ready   (i_disp_ready),
      .o_count        (o_count),
      .o_stall_cycles (o_stall_cycles)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- check helper ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   always @(posedge clk) begin : model
      int  sz;
      int  n;
      bit  rdy;
      if (i_reset) begin
         exp_q.delete();
         exp_stall = 0;
      end else if (i_flush) begin
         exp_q.delete();
      end else begin
         sz  = exp_q.size();
         rdy = (SZ - sz) >= 2;
         n   = (sz < 2) ? sz : 2;
`ifdef MYOOO_IBUF_PERF_EN
         if (i_fetch_valid && !rdy && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 1;
`endif
         if (n > 0 && i_disp_ready) repeat (n) void'(exp_q.pop_front());
         if (i_fetch_valid && rdy) begin
            if (i_fetch_mask[0]) exp_q.push_back({i_fetch_pc, i_fetch_inst[31:0]});
            if (i_fetch_mask[1]) exp_q.push_back({i_fetch_pc + 39'd4, i_fetch_inst[63:32]});
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin : compare
      int n;
      if (run && !i_reset) begin
         n = (exp_q.size() < 2) ? exp_q.size() : 2;
         chk("count", 64'(o_count), 64'(exp_q.size()));
         chk("fetch_ready", 64'(o_fetch_ready), 64'(((SZ - exp_q.size()) >= 2) && !i_flush));
         chk("disp_valid", 64'(o_disp_valid), 64'((n != 0) && !i_flush));
         chk("disp_mask", 64'(o_disp_mask), 64'((1 << n) - 1));
         for (int k = 0; k < 2; k++) begin
            if (k < n) begin
               chk($sformatf("lane%0d_pc", k), 64'(o_disp_pc[k*PC_W +: PC_W]), 64'(exp_q[k][PC_W+31:32]));
               chk($sformatf("lane%0d_inst", k), 64'(o_disp_inst[k*32 +: 32]), 64'(exp_q[k][31:0]));
            end else begin
               chk($sformatf("lane%0d_pc_idle", k), 64'(o_disp_pc[k*PC_W +: PC_W]), 64'd0);
               chk($sformatf("lane%0d_inst_idle", k), 64'(o_disp_inst[k*32 +: 32]), 64'd0);
            end
         end
         chk("stall", 64'(o_stall_cycles), 64'(exp_stall));
      end
   end

   // ---------------- driver tasks ----------------
   function automatic logic [31:0] mk_inst(input logic [PC_W-1:0] pc);
      return pc[31:0] ^ 32'hA500_0013;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      i_fetch_valid = 1'b0;
      i_fetch_pc    = '0;
      i_fetch_inst  = '0;
      i_fetch_mask  = 2'b00;
   endtask

   task automatic drive_fetch(input logic [PC_W-1:0] pc, input logic [63:0] inst, input logic [1:0] mask);
      i_fetch_valid = 1'b1;
      i_fetch_pc    = pc;
      i_fetch_inst  = inst;
      i_fetch_mask  = mask;
   endtask

   task automatic push_group(input logic [PC_W-1:0] pc);
      drive_fetch(pc, {mk_inst(pc + 39'd4), mk_inst(pc)}, 2'b11);
      tick();
      drive_idle();
   endtask

   task automatic drain(input int cycles);
      i_disp_ready = 1'b1;
      repeat (cycles) tick();
      i_disp_ready = 1'b0;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      i_reset      = 1'b1;
      i_flush      = 1'b0;
      i_disp_ready = 1'b0;
      drive_idle();
      repeat (2) tick();
      @(negedge clk);
      chk("rst_fetch_ready", 64'(o_fetch_ready), 64'd1);
      chk("rst_disp_valid", 64'(o_disp_valid), 64'd0);
      chk("rst_disp_mask", 64'(o_disp_mask), 64'd0);
      chk("rst_count", 64'(o_count), 64'd0);
      chk("rst_stall", 64'(o_stall_cycles), 64'd0);
      tick();
      i_reset = 1'b0;
      run     = 1'b1;
      tick();

      // First group becomes visible the cycle after it is pushed.
      drive_fetch(39'h1000, {32'h0020_0093, 32'h0010_0013}, 2'b11);
      tick();
      drive_idle();
      @(negedge clk);
      chk("first_mask", 64'(o_disp_mask), 64'h3);
      chk("first_l0_pc", 64'(o_disp_pc[38:0]), 64'h1000);
      chk("first_l0_inst", 64'(o_disp_inst[31:0]), 64'h0010_0013);
      chk("first_l1_pc", 64'(o_disp_pc[77:39]), 64'h1004);
      chk("first_l1_inst", 64'(o_disp_inst[63:32]), 64'h0020_0093);
      chk("first_count", 64'(o_count), 64'd2);

      // Fill to full.
      push_group(39'h1008);
      push_group(39'h1010);
      @(negedge clk);
      chk("full_count", 64'(o_count), 64'd6);
      chk("full_ready", 64'(o_fetch_ready), 64'd0);
      drain(3);
      @(negedge clk);
      chk("drained_count", 64'(o_count), 64'd0);

      // Count 5 still refuses a 1-slot group.
      push_group(39'h1100);
      push_group(39'h1108);
      drive_fetch(39'h1110, {32'h0, mk_inst(39'h1110)}, 2'b01);
      tick();
      drive_idle();
      @(negedge clk);
      chk("five_count", 64'(o_count), 64'd5);
      chk("five_ready", 64'(o_fetch_ready), 64'd0);
      drive_fetch(39'h1118, {32'h0, mk_inst(39'h1118)}, 2'b01);
      tick();
      drive_idle();
      @(negedge clk);
      chk("five_reject_count", 64'(o_count), 64'd5);
      drain(3);

      // Slot-1-only group at an 8-byte aligned PC.
      drive_fetch(39'h2008, {32'h0BAD_F00D, 32'hDEAD_BEEF}, 2'b10);
      tick();
      drive_idle();
      @(negedge clk);
      chk("m10_l0_pc", 64'(o_disp_pc[38:0]), 64'h200C);
      chk("m10_l0_inst", 64'(o_disp_inst[31:0]), 64'h0BAD_F00D);
      chk("m10_mask", 64'(o_disp_mask), 64'h1);
      chk("m10_count", 64'(o_count), 64'd1);
      drain(1);

      // Streaming push 2 / pop 2 across the pointer wrap.
      push_group(39'h3000);
      i_disp_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive_fetch(39'h3008 + 39'(8 * i), {mk_inst(39'h300C + 39'(8 * i)), mk_inst(39'h3008 + 39'(8 * i))}, 2'b11);
         @(negedge clk);
         chk("stream_l0_pc", 64'(o_disp_pc[38:0]), 64'h3000 + 64'(8 * i));
         chk("stream_l1_pc", 64'(o_disp_pc[77:39]), 64'h3004 + 64'(8 * i));
         tick();
      end
      drive_idle();
      i_disp_ready = 1'b0;
      @(negedge clk);
      chk("stream_count", 64'(o_count), 64'd2);
      chk("stream_last_pc", 64'(o_disp_pc[38:0]), 64'h3050);
      drain(1);

      // Flush with a concurrent fetch: nothing is stored.
      push_group(39'h4100);
      push_group(39'h4108);
      i_flush      = 1'b1;
      i_disp_ready = 1'b1;
      drive_fetch(39'h4000, {mk_inst(39'h4004), mk_inst(39'h4000)}, 2'b11);
      @(negedge clk);
      chk("flush_disp_valid", 64'(o_disp_valid), 64'd0);
      chk("flush_fetch_ready", 64'(o_fetch_ready), 64'd0);
      chk("flush_count_held", 64'(o_count), 64'd4);
      tick();
      i_flush      = 1'b0;
      i_disp_ready = 1'b0;
      drive_idle();
      @(negedge clk);
      chk("post_flush_count", 64'(o_count), 64'd0);
      chk("post_flush_valid", 64'(o_disp_valid), 64'd0);
      push_group(39'h5000);
      @(negedge clk);
      chk("post_flush_pc", 64'(o_disp_pc[38:0]), 64'h5000);
      chk("post_flush_count2", 64'(o_count), 64'd2);

      // Asynchronous reset mid-operation clears immediately.
      @(posedge clk);
      #2;
      i_reset = 1'b1;
      #1;
      chk("async_rst_count", 64'(o_count), 64'd0);
      chk("async_rst_valid", 64'(o_disp_valid), 64'd0);
      chk("async_rst_ready", 64'(o_fetch_ready), 64'd1);
      tick();
      tick();
      i_reset = 1'b0;
      tick();

      // Stall counting against a full buffer.
      push_group(39'h6000);
      push_group(39'h6008);
      push_group(39'h6010);
      drive_fetch(39'h7000, {mk_inst(39'h7004), mk_inst(39'h7000)}, 2'b11);
      repeat (7) tick();
      drive_idle();
      @(negedge clk);
      chk("stall_count_full", 64'(o_count), 64'd6);
`ifdef MYOOO_IBUF_PERF_EN
      chk("stall_cycles", 64'(o_stall_cycles), 64'd7);
`else
      chk("stall_cycles", 64'(o_stall_cycles), 64'd0);
`endif
      drain(3);
      @(negedge clk);
      chk("final_count", 64'(o_count), 64'd0);
      run = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
